// File: rtl/register_coherence_manager_if.sv
// Bus between the processor cores / multi-processor manager and the register
// coherence manager; master drives core state, slave returns the merged view.
interface register_coherence_manager_if #(
    parameter int CORE_NUM        = 2,
    parameter int REGISTER_AMOUNT = 32,
    parameter int REGISTER_WIDTH  = 64
);
    localparam int CORE_W        = (CORE_NUM > 1) ? $clog2(CORE_NUM) : 1;
    localparam int REG_CTN_WIDTH = $clog2(REGISTER_AMOUNT);

    logic [REGISTER_WIDTH-1:0] core_registers [0:CORE_NUM-1][0:REGISTER_AMOUNT-1];
    logic [CORE_NUM-1:0]       core_idle;
    logic [CORE_NUM-1:0]       boot_renew;
    logic [REG_CTN_WIDTH-1:0]  register_num [0:CORE_NUM-1];
    logic                      main_program_state;
    logic [REGISTER_WIDTH-1:0] ra_register;

    logic [CORE_NUM-1:0]       sync_pulse;
    logic [CORE_NUM-1:0]       core_busy;
    logic [CORE_W-1:0]         owner_map [0:REGISTER_AMOUNT-1];
    logic                      synchronized_processors;
    logic                      protocol_error;
    logic [REGISTER_WIDTH-1:0] registers_renew [0:REGISTER_AMOUNT-1];

    modport master (
        output core_registers, core_idle, boot_renew, register_num,
               main_program_state, ra_register,
        input  sync_pulse, core_busy, owner_map, synchronized_processors,
               protocol_error, registers_renew
    );

    modport slave (
        input  core_registers, core_idle, boot_renew, register_num,
               main_program_state, ra_register,
        output sync_pulse, core_busy, owner_map, synchronized_processors,
               protocol_error, registers_renew
    );
endinterface

// File: rtl/register_coherence_manager.sv
// Tracks which of CORE_NUM cores owns the newest copy of each register, drives
// the merged register view and strobes a sync pulse to every stale core.
module register_coherence_manager #(
    parameter int CORE_NUM        = 2,
    parameter int REGISTER_AMOUNT = 32,
    parameter int REGISTER_WIDTH  = 64,
    parameter int RA_INDEX        = 1
) (
    input logic clk,
    input logic rst_n,
    register_coherence_manager_if.slave bus
);
    localparam int CORE_W        = (CORE_NUM > 1) ? $clog2(CORE_NUM) : 1;
    localparam int REG_CTN_WIDTH = $clog2(REGISTER_AMOUNT);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        UPDATING = 2'd1,
        SYNC     = 2'd2
    } state_e;

    state_e                   state_q   [0:CORE_NUM-1];
    state_e                   state_d   [0:CORE_NUM-1];
    logic [REG_CTN_WIDTH-1:0] reg_buf_q [0:CORE_NUM-1];
    logic [REG_CTN_WIDTH-1:0] reg_buf_d [0:CORE_NUM-1];
    logic [CORE_W-1:0]        owner_q   [0:REGISTER_AMOUNT-1];
    logic [CORE_W-1:0]        owner_d   [0:REGISTER_AMOUNT-1];

    logic [CORE_NUM-1:0] pending_q, pending_d;
    logic [CORE_NUM-1:0] prev_idle_q, prev_idle_d;
    logic [CORE_NUM-1:0] sync_pulse_q, sync_pulse_d;
    logic [CORE_NUM-1:0] core_busy_q, core_busy_d;
    logic                protocol_error_q, protocol_error_d;

    logic [CORE_NUM-1:0] idle_rise;
    logic [CORE_NUM-1:0] accept;
    logic [CORE_NUM-1:0] complete;
    logic [CORE_NUM-1:0] sync_clear;
    logic [CORE_NUM-1:0] others;
    logic                any_updating;

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        idle_rise        = bus.core_idle & ~prev_idle_q;
        prev_idle_d      = bus.core_idle;
        accept           = '0;
        complete         = '0;
        sync_clear       = '0;
        others           = '0;
        protocol_error_d = protocol_error_q;
        sync_pulse_d     = '0;
        core_busy_d      = '0;
        pending_d        = '0;

        any_updating = 1'b0;
        for (int c = 0; c < CORE_NUM; c++) begin
            if (state_q[c] == UPDATING) any_updating = 1'b1;
        end

        for (int c = 0; c < CORE_NUM; c++) begin
            state_d[c]   = state_q[c];
            reg_buf_d[c] = reg_buf_q[c];
            case (state_q[c])
                IDLE: begin
                    if (bus.boot_renew[c]) begin
                        state_d[c]   = UPDATING;
                        reg_buf_d[c] = bus.register_num[c];
                        accept[c]    = 1'b1;
                    end else if (pending_q[c] && !any_updating) begin
                        state_d[c]    = SYNC;
                        sync_clear[c] = 1'b1;
                    end
                end
                UPDATING: begin
                    if (idle_rise[c]) begin
                        state_d[c]  = IDLE;
                        complete[c] = 1'b1;
                    end
                end
                SYNC:    state_d[c] = IDLE;
                default: state_d[c] = IDLE;
            endcase
            if (bus.boot_renew[c] && (state_q[c] != IDLE)) protocol_error_d = 1'b1;
            sync_pulse_d[c] = (state_d[c] == SYNC);
            core_busy_d[c]  = (state_d[c] == UPDATING);
        end

        // A new update by any other core makes this core stale; set beats clear.
        for (int k = 0; k < CORE_NUM; k++) begin
            others       = accept;
            others[k]    = 1'b0;
            pending_d[k] = (pending_q[k] & ~sync_clear[k]) | (|others);
        end

        // Descending scan so the lowest completing core index is written last and wins.
        for (int r = 0; r < REGISTER_AMOUNT; r++) owner_d[r] = owner_q[r];
        for (int c = CORE_NUM - 1; c >= 0; c--) begin
            if (complete[c]) owner_d[reg_buf_q[c]] = CORE_W'(c);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the owner table drives the merged view, so unlike a plain data memory it must be reset.
            for (int c = 0; c < CORE_NUM; c++) begin
                state_q[c]   <= IDLE;
                reg_buf_q[c] <= '0;
            end
            for (int r = 0; r < REGISTER_AMOUNT; r++) owner_q[r] <= '0;
            pending_q        <= '0;
            prev_idle_q      <= '1;
            sync_pulse_q     <= '0;
            core_busy_q      <= '0;
            protocol_error_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            for (int c = 0; c < CORE_NUM; c++) begin
                state_q[c]   <= state_d[c];
                reg_buf_q[c] <= reg_buf_d[c];
            end
            for (int r = 0; r < REGISTER_AMOUNT; r++) owner_q[r] <= owner_d[r];
            pending_q        <= pending_d;
            prev_idle_q      <= prev_idle_d;
            sync_pulse_q     <= sync_pulse_d;
            core_busy_q      <= core_busy_d;
            protocol_error_q <= protocol_error_d;
        end
    end

    always_comb begin
        bus.sync_pulse              = sync_pulse_q;
        bus.core_busy               = core_busy_q;
        bus.synchronized_processors = ~|pending_q;
        bus.protocol_error          = protocol_error_q;
        for (int r = 0; r < REGISTER_AMOUNT; r++) begin
            bus.owner_map[r] = owner_q[r];
            if (r == 0) begin
                bus.registers_renew[r] = '0;
            end else if (r == RA_INDEX) begin
                bus.registers_renew[r] = bus.ra_register;
            end else if (bus.main_program_state) begin
                bus.registers_renew[r] = bus.core_registers[owner_q[r]][r];
            end else begin
                bus.registers_renew[r] = bus.core_registers[0][r];
            end
        end
    end
endmodule

// File: tb/tb_register_coherence_manager.sv
// Directed bench for a 4-core register_coherence_manager; sync pulses are
// checked against a scoreboard of expected (mask, cycle) entries.
module tb_register_coherence_manager;
    localparam int CN = 4;
    localparam int RA = 32;
    localparam int RW = 64;

    typedef struct {
        logic [CN-1:0] mask;
        int            cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    exp_t sb[$];

    register_coherence_manager_if #(.CORE_NUM(CN), .REGISTER_AMOUNT(RA), .REGISTER_WIDTH(RW)) bus ();

    register_coherence_manager #(
        .CORE_NUM(CN), .REGISTER_AMOUNT(RA), .REGISTER_WIDTH(RW), .RA_INDEX(1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Sync-pulse scoreboard: each entry must appear exactly on its cycle.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            check("sync_pulse", 64'(bus.sync_pulse), 64'(sb[0].mask));
            void'(sb.pop_front());
        end else if (bus.sync_pulse != '0) begin
            check("sync_unexpected", 64'(bus.sync_pulse), 64'(0));
        end
    end

    task automatic boot(input int core, input int rnum);
        bus.core_idle[core]    = 1'b0;
        bus.boot_renew[core]   = 1'b1;
        bus.register_num[core] = 5'(rnum);
        @(negedge clk);
        bus.boot_renew[core] = 1'b0;
    endtask

    task automatic rise(input int core, input logic [CN-1:0] exp_mask);
        bus.core_idle[core] = 1'b1;
        sb.push_back('{exp_mask, cyc + 2});
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n                  = 1'b0;
        bus.core_idle          = '1;
        bus.boot_renew         = '0;
        bus.main_program_state = 1'b1;
        bus.ra_register        = 64'hA5A5_0001_DEAD_BEEF;
        for (int c = 0; c < CN; c++) begin
            bus.register_num[c] = '0;
            for (int r = 0; r < RA; r++) bus.core_registers[c][r] = {$urandom, 8'(c), 24'(r)};
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        for (int r = 0; r < RA; r++) check("rst_owner", 64'(bus.owner_map[r]), 64'(0));
        check("rst_synced", 64'(bus.synchronized_processors), 64'(1));
        check("rst_sync_pulse", 64'(bus.sync_pulse), 64'(0));
        check("rst_busy", 64'(bus.core_busy), 64'(0));
        check("rst_perr", 64'(bus.protocol_error), 64'(0));
        check("rst_renew0", bus.registers_renew[0], 64'(0));
        check("rst_renew1", bus.registers_renew[1], bus.ra_register);
        check("rst_renew5", bus.registers_renew[5], bus.core_registers[0][5]);

        // Core 2 updates register 5; the other three cores resync once
        boot(2, 5);
        check("s1_busy", 64'(bus.core_busy), 64'(4'b0100));
        check("s1_synced_lo", 64'(bus.synchronized_processors), 64'(0));
        rise(2, 4'b1011);
        check("s1_owner5", 64'(bus.owner_map[5]), 64'(2));
        check("s1_busy_off", 64'(bus.core_busy), 64'(0));
        check("s1_renew5", bus.registers_renew[5], bus.core_registers[2][5]);
        repeat (3) @(negedge clk);
        check("s1_synced_hi", 64'(bus.synchronized_processors), 64'(1));

        // Owner of the RA register moves but the output stays ra_register
        boot(2, 1);
        rise(2, 4'b1011);
        check("ra_owner", 64'(bus.owner_map[1]), 64'(2));
        check("ra_renew", bus.registers_renew[1], bus.ra_register);
        repeat (3) @(negedge clk);

        // Cores 1 and 3 complete register 7 on the same edge: core 1 wins
        bus.core_idle[1]    = 1'b0;
        bus.core_idle[3]    = 1'b0;
        bus.boot_renew[1]   = 1'b1;
        bus.boot_renew[3]   = 1'b1;
        bus.register_num[1] = 5'd7;
        bus.register_num[3] = 5'd7;
        @(negedge clk);
        bus.boot_renew = '0;
        check("s2_busy", 64'(bus.core_busy), 64'(4'b1010));
        bus.core_idle[1] = 1'b1;
        bus.core_idle[3] = 1'b1;
        sb.push_back('{4'b1111, cyc + 2});
        @(negedge clk);
        check("s2_owner7", 64'(bus.owner_map[7]), 64'(1));
        check("s2_renew7", bus.registers_renew[7], bus.core_registers[1][7]);
        bus.main_program_state = 1'b0;
        #1;
        check("s2_renew7_core0", bus.registers_renew[7], bus.core_registers[0][7]);
        bus.main_program_state = 1'b1;
        repeat (3) @(negedge clk);
        check("s2_synced_hi", 64'(bus.synchronized_processors), 64'(1));

        // Pending syncs wait while core 0 is still updating
        boot(0, 10);
        repeat (4) begin
            check("s3_hold_pulse", 64'(bus.sync_pulse), 64'(0));
            check("s3_hold_synced", 64'(bus.synchronized_processors), 64'(0));
            @(negedge clk);
        end
        rise(0, 4'b1110);
        check("s3_owner10", 64'(bus.owner_map[10]), 64'(0));
        repeat (3) @(negedge clk);

        // Re-boot while updating: sticky error, original target kept
        check("s4_perr_pre", 64'(bus.protocol_error), 64'(0));
        boot(1, 12);
        bus.boot_renew[1]   = 1'b1;
        bus.register_num[1] = 5'd13;
        @(negedge clk);
        bus.boot_renew[1] = 1'b0;
        check("s4_perr", 64'(bus.protocol_error), 64'(1));
        check("s4_busy", 64'(bus.core_busy), 64'(4'b0010));
        repeat (2) @(negedge clk);
        rise(1, 4'b1101);
        check("s4_owner12", 64'(bus.owner_map[12]), 64'(1));
        check("s4_owner13", 64'(bus.owner_map[13]), 64'(0));
        check("s4_perr_sticky", 64'(bus.protocol_error), 64'(1));
        repeat (3) @(negedge clk);

        // Reset aborts core 3's update of register 9
        boot(3, 9);
        check("s5_busy", 64'(bus.core_busy), 64'(4'b1000));
        rst_n = 1'b0;
        #1;
        check("s5_owner9", 64'(bus.owner_map[9]), 64'(0));
        check("s5_busy_rst", 64'(bus.core_busy), 64'(0));
        check("s5_synced", 64'(bus.synchronized_processors), 64'(1));
        check("s5_perr_clr", 64'(bus.protocol_error), 64'(0));
        check("s5_owner7_clr", 64'(bus.owner_map[7]), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.core_idle[3] = 1'b1;
        repeat (3) @(negedge clk);
        check("s5_owner9_post", 64'(bus.owner_map[9]), 64'(0));
        check("s5_busy_post", 64'(bus.core_busy), 64'(0));
        check("s5_renew0", bus.registers_renew[0], 64'(0));
        check("s5_renew1", bus.registers_renew[1], bus.ra_register);

        repeat (2) @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'(0));
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
